// File: rtl/alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_unit
// Description : Execute-stage ALU. Logic, arithmetic and compare ops finish in
//               one cycle. Shifts run iteratively, SHIFT_STEP bits per cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_unit #(
    parameter int WIDTH      = 32,
    parameter int SHIFT_STEP = 1
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_ctrl,
    input  logic [1:0]       equal_comp,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             branch_taken,
    output logic             illegal_op
);

    localparam int SHW  = $clog2(WIDTH);
    localparam int SHW1 = SHW + 1;
    localparam logic [SHW1-1:0] c_STEP = SHW1'(SHIFT_STEP);

    localparam logic [3:0] c_AND  = 4'b0000;
    localparam logic [3:0] c_OR   = 4'b0001;
    localparam logic [3:0] c_ADD  = 4'b0010;
    localparam logic [3:0] c_XOR  = 4'b0011;
    localparam logic [3:0] c_SLL  = 4'b0100;
    localparam logic [3:0] c_SLT  = 4'b0101;
    localparam logic [3:0] c_SUB  = 4'b0110;
    localparam logic [3:0] c_SLTU = 4'b0111;
    localparam logic [3:0] c_SRL  = 4'b1000;
    localparam logic [3:0] c_SRA  = 4'b1001;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t           r_state;
    logic [3:0]       r_ctrl;
    logic [1:0]       r_eq;
    logic [WIDTH-1:0] r_work;
    logic [SHW1-1:0]  r_rem;

    logic [SHW1-1:0]  w_shamt;
    logic             w_is_shift;
    logic             w_illegal;
    logic [WIDTH-1:0] w_alu;
    logic [SHW1-1:0]  w_step;
    logic [WIDTH-1:0] w_shifted;

    function automatic logic branch_of(input logic [1:0] eq, input logic z);
        branch_of = (eq == 2'b11) ? z : ((eq == 2'b10) ? !z : 1'b0);
    endfunction

    assign in_ready = (r_state == S_IDLE);

    always_comb begin
        w_shamt    = {1'b0, op_b[SHW-1:0]};
        w_is_shift = (alu_ctrl == c_SLL) || (alu_ctrl == c_SRL) || (alu_ctrl == c_SRA);
        w_illegal  = (alu_ctrl >= 4'b1010);
        w_alu      = '0;
        case (alu_ctrl)
            c_AND:  w_alu = op_a & op_b;
            c_OR:   w_alu = op_a | op_b;
            c_ADD:  w_alu = op_a + op_b;
            c_XOR:  w_alu = op_a ^ op_b;
            c_SUB:  w_alu = op_a - op_b;
            c_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            c_SLTU: w_alu = {{(WIDTH-1){1'b0}}, (op_a < op_b)};
            c_SLL, c_SRL, c_SRA: w_alu = op_a;   // only reached here with shamt == 0
            default: w_alu = '0;
        endcase
    end

    // One iteration of the shifter: move by the smaller of SHIFT_STEP and what remains.
    always_comb begin
        w_step    = (r_rem < c_STEP) ? r_rem : c_STEP;
        w_shifted = r_work;
        case (r_ctrl)
            c_SLL:   w_shifted = r_work << w_step;
            c_SRL:   w_shifted = r_work >> w_step;
            c_SRA:   w_shifted = $unsigned($signed(r_work) >>> w_step);
            default: w_shifted = r_work;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_ctrl       <= '0;
            r_eq         <= '0;
            r_work       <= '0;
            r_rem        <= '0;
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            branch_taken <= 1'b0;
            illegal_op   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ctrl <= alu_ctrl;
                        r_eq   <= equal_comp;
                        if (w_is_shift && (w_shamt != '0)) begin
                            r_work  <= op_a;
                            r_rem   <= w_shamt;
                            r_state <= S_SHIFT;
                        end else begin
                            result       <= w_alu;
                            zero         <= (w_alu == '0);
                            branch_taken <= w_illegal ? 1'b0 : branch_of(equal_comp, (w_alu == '0));
                            illegal_op   <= w_illegal;
                            out_valid    <= 1'b1;
                            r_state      <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_shifted;
                    r_rem  <= r_rem - w_step;
                    if (r_rem == w_step) begin
                        result       <= w_shifted;
                        zero         <= (w_shifted == '0);
                        branch_taken <= branch_of(r_eq, (w_shifted == '0));
                        illegal_op   <= 1'b0;
                        out_valid    <= 1'b1;
                        r_state      <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_unit
// Description : Directed bench for alu_exec_unit, SHIFT_STEP=1 and SHIFT_STEP=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_unit;

    logic        clk;
    logic        reset_n;
    logic        in_valid;
    logic [3:0]  alu_ctrl;
    logic [1:0]  equal_comp;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        out_ready;

    logic        in_ready,  out_valid,  zero,  branch_taken,  illegal_op;
    logic [31:0] result;
    logic        in_ready4, out_valid4, zero4, branch_taken4, illegal_op4;
    logic [31:0] result4;

    int checks   = 0;
    int failures = 0;

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
        .alu_ctrl(alu_ctrl), .equal_comp(equal_comp), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid), .out_ready(out_ready), .result(result), .zero(zero),
        .branch_taken(branch_taken), .illegal_op(illegal_op)
    );

    alu_exec_unit #(.WIDTH(32), .SHIFT_STEP(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready4),
        .alu_ctrl(alu_ctrl), .equal_comp(equal_comp), .op_a(op_a), .op_b(op_b),
        .out_valid(out_valid4), .out_ready(out_ready), .result(result4), .zero(zero4),
        .branch_taken(branch_taken4), .illegal_op(illegal_op4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one op to both units, measure accept->out_valid latency, check outputs.
    task automatic do_op(input string tag, input logic [3:0] ctrl, input logic [1:0] eq,
                         input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] er, input logic ez, input logic eb, input logic ei,
                         input int l1, input int l4, input bit consume);
        int cyc, lat1, lat4;
        @(negedge clk);
        chk({tag, ".in_ready"}, {31'd0, in_ready & in_ready4}, 32'd1);
        in_valid = 1'b1; alu_ctrl = ctrl; equal_comp = eq; op_a = a; op_b = b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1; lat1 = 0; lat4 = 0;
        if (out_valid)  lat1 = 1;
        if (out_valid4) lat4 = 1;
        while ((lat1 == 0 || lat4 == 0) && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
            if (lat1 == 0 && out_valid)  lat1 = cyc;
            if (lat4 == 0 && out_valid4) lat4 = cyc;
        end
        chk({tag, ".lat1"}, lat1, l1);
        chk({tag, ".lat4"}, lat4, l4);
        chk({tag, ".result1"}, result, er);
        chk({tag, ".result4"}, result4, er);
        chk({tag, ".flags1"}, {29'd0, zero, branch_taken, illegal_op}, {29'd0, ez, eb, ei});
        chk({tag, ".flags4"}, {29'd0, zero4, branch_taken4, illegal_op4}, {29'd0, ez, eb, ei});
        chk({tag, ".busy"}, {30'd0, in_ready, in_ready4}, 32'd0);
        if (consume) begin
            @(negedge clk); out_ready = 1'b1;
            @(posedge clk); #1; out_ready = 1'b0;
            chk({tag, ".released"}, {28'd0, out_valid, out_valid4, in_ready, in_ready4}, 32'b0011);
        end
    endtask

    initial begin
        reset_n = 1'b0; in_valid = 1'b0; alu_ctrl = '0; equal_comp = '0;
        op_a = '0; op_b = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset.outs", {27'd0, out_valid, zero, branch_taken, illegal_op, in_ready}, 32'b00001);
        chk("reset.result", result, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // Arithmetic wrap
        do_op("add_ovf", 4'b0010, 2'b00, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 1'b0, 1'b0, 1'b0, 1, 1, 1);
        do_op("sub_wrap", 4'b0110, 2'b00, 32'h0, 32'h1, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 1, 1, 1);
        do_op("and", 4'b0000, 2'b00, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1, 1, 1);
        do_op("or_eq01", 4'b0001, 2'b01, 32'h0F, 32'hF0, 32'hFF, 1'b0, 1'b0, 1'b0, 1, 1, 1);

        // Shifts: latency 1 + ceil(shamt/step)
        do_op("sra31", 4'b1001, 2'b00, 32'h8000_0000, 32'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0, 32, 9, 1);
        do_op("sra_sh0", 4'b1001, 2'b00, 32'h8000_0001, 32'd32, 32'h8000_0001, 1'b0, 1'b0, 1'b0, 1, 1, 1);
        do_op("srl4", 4'b1000, 2'b00, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 1'b0, 1'b0, 5, 2, 1);
        do_op("sll5", 4'b0100, 2'b10, 32'h3, 32'd5, 32'h60, 1'b0, 1'b1, 1'b0, 6, 3, 1);
        do_op("srl_zero", 4'b1000, 2'b11, 32'h0000_0004, 32'd3, 32'h0, 1'b1, 1'b1, 1'b0, 4, 2, 1);

        // Compare / branch
        do_op("xor_eq11", 4'b0011, 2'b11, 32'h5, 32'h5, 32'h0, 1'b1, 1'b1, 1'b0, 1, 1, 1);
        do_op("sltu", 4'b0111, 2'b11, 32'h1, 32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0, 1, 1, 1);
        do_op("slt_neg", 4'b0101, 2'b10, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b1, 1'b0, 1, 1, 1);
        do_op("slt_pos", 4'b0101, 2'b11, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b1, 1'b0, 1, 1, 1);

        // Backpressure: DONE held for 5 cycles while a new op is offered
        do_op("hold", 4'b0010, 2'b00, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1'b0, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1; alu_ctrl = 4'b0011; op_a = 32'hAAAA_0000 + i; op_b = 32'h1;
            @(posedge clk); #1;
            chk("hold.state", {29'd0, out_valid, out_valid4, in_ready | in_ready4}, 32'b110);
            chk("hold.result", result ^ result4 ^ 32'd5, 32'd5);
        end
        in_valid = 1'b0;
        @(negedge clk); out_ready = 1'b1;
        @(posedge clk); #1; out_ready = 1'b0;
        chk("hold.release", {28'd0, out_valid, out_valid4, in_ready, in_ready4}, 32'b0011);
        @(posedge clk); #1;
        chk("hold.no_replay", {30'd0, out_valid, out_valid4}, 32'd0);

        // Illegal code
        do_op("illegal", 4'b1100, 2'b11, 32'h1234, 32'h5678, 32'h0, 1'b1, 1'b0, 1'b1, 1, 1, 1);

        // Reset in the middle of a shift
        @(negedge clk);
        in_valid = 1'b1; alu_ctrl = 4'b0100; equal_comp = 2'b00; op_a = 32'h1; op_b = 32'd20;
        @(posedge clk); #1; in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("midshift.busy", {30'd0, in_ready, in_ready4}, 32'd0);
        reset_n = 1'b0;
        #1;
        chk("rst.outs", {26'd0, out_valid, out_valid4, zero, illegal_op, in_ready, in_ready4}, 32'b000011);
        chk("rst.result", result | result4, 32'd0);
        @(negedge clk); reset_n = 1'b1;
        do_op("post_rst_add", 4'b0010, 2'b10, 32'd10, 32'd20, 32'd30, 1'b0, 1'b1, 1'b0, 1, 1, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
